// File: rtl/vga_sync_receiver.sv
// Sink-side monitor for a VGA-style timing stream: measures line/frame periods, recovers pixel
// coordinates and declares lock. Define VGA_RX_DE_CHECK_EN to also police video_on extents.
module vga_sync_receiver #(
  parameter int unsigned H_TOTAL     = 1440,
  parameter int unsigned V_TOTAL     = 831,
  parameter int unsigned H_VISIBLE   = 1280,
  parameter int unsigned V_VISIBLE   = 800,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        video_on,
  output logic [10:0] rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_de,
  output logic [11:0] h_meas,
  output logic [10:0] v_meas,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err
);

  localparam int unsigned HW = 12;
  localparam int unsigned VW = 11;
  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned GW = 4;

  localparam logic [HW-1:0] H_MAX  = '1;
  localparam logic [VW-1:0] V_MAX  = '1;
  localparam logic [HW-1:0] H_EXP  = HW'(H_TOTAL);
  localparam logic [VW-1:0] V_EXP  = VW'(V_TOTAL);
  localparam logic [GW-1:0] LOCK_W = GW'(LOCK_FRAMES);

  if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15 || H_VISIBLE > H_TOTAL || V_VISIBLE > V_TOTAL)
  begin : g_cfg_err
    $error("vga_sync_receiver: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  logic          r_hs_q, r_vs_q, r_de_q;
  logic          w_hs_rise, w_vs_rise, w_de_rise, w_de_fall;
  logic [HW-1:0] r_hcnt, r_h_meas, w_h_meas_new;
  logic          r_h_armed;
  logic [VW-1:0] r_vcnt, r_v_meas, w_vcnt_new;
  logic          r_frame_bad;
  logic [XW-1:0] r_rx_x;
  logic [YW-1:0] r_rx_y, r_row, w_row_cur;
  logic          r_rx_de;
  state_t        r_state, w_state_nxt;
  logic [GW-1:0] r_good, w_good_nxt;
  logic          w_err_nxt, r_err, r_locked, r_fs;
  logic          w_checking, w_los, w_line_bad, w_frame_bad;
  logic          w_de_line_bad, w_de_frame_bad;

  assign w_hs_rise = hsync & ~r_hs_q;
  assign w_vs_rise = vsync & ~r_vs_q;
  assign w_de_rise = video_on & ~r_de_q;
  assign w_de_fall = ~video_on & r_de_q;

  assign w_h_meas_new = (r_hcnt == H_MAX) ? H_MAX : r_hcnt + 12'd1;
  // A line that coincides with the frame edge is counted before the frame closes.
  assign w_vcnt_new   = (w_hs_rise && (r_vcnt != V_MAX)) ? r_vcnt + 11'd1 : r_vcnt;
  assign w_row_cur    = w_vs_rise ? '0 : r_row;

  assign w_checking  = (r_state != ST_IDLE);
  assign w_los       = (r_hcnt == H_MAX);
  assign w_line_bad  = (w_hs_rise && r_h_armed && (w_h_meas_new != H_EXP)) || w_de_line_bad;
  assign w_frame_bad = (w_vcnt_new != V_EXP) || r_frame_bad || w_line_bad || w_de_frame_bad;

`ifdef VGA_RX_DE_CHECK_EN
  localparam logic [HW-1:0] HV_EXP = HW'(H_VISIBLE);
  localparam logic [VW-1:0] VV_EXP = VW'(V_VISIBLE);

  logic [HW-1:0] r_de_cnt;
  logic [VW-1:0] r_de_lines, w_de_lines_new;
  logic          w_de_line_end;

  assign w_de_line_end  = w_hs_rise && (r_de_cnt != '0);
  assign w_de_lines_new = w_de_line_end ? r_de_lines + 11'd1 : r_de_lines;
  assign w_de_line_bad  = w_de_line_end && r_h_armed && (r_de_cnt != HV_EXP);
  assign w_de_frame_bad = (w_de_lines_new != VV_EXP);

  // Per-line active clock count and per-frame active line count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_de_cnt   <= '0;
      r_de_lines <= '0;
    end else begin
      if (w_hs_rise)                          r_de_cnt <= video_on ? 12'd1 : 12'd0;
      else if (video_on && r_de_cnt != H_MAX) r_de_cnt <= r_de_cnt + 12'd1;
      r_de_lines <= w_vs_rise ? '0 : w_de_lines_new;
    end
  end
`else
  assign w_de_line_bad  = 1'b0;
  assign w_de_frame_bad = 1'b0;
`endif

  // Edge capture, period measurement and coordinate recovery.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_q      <= 1'b0;
      r_vs_q      <= 1'b0;
      r_de_q      <= 1'b0;
      r_hcnt      <= '0;
      r_h_armed   <= 1'b0;
      r_h_meas    <= '0;
      r_vcnt      <= '0;
      r_v_meas    <= '0;
      r_frame_bad <= 1'b0;
      r_row       <= '0;
      r_rx_x      <= '0;
      r_rx_y      <= '0;
      r_rx_de     <= 1'b0;
      r_fs        <= 1'b0;
    end else begin
      r_hs_q <= hsync;
      r_vs_q <= vsync;
      r_de_q <= video_on;

      if (w_hs_rise) begin
        r_hcnt    <= '0;
        r_h_armed <= 1'b1;
        if (r_h_armed) r_h_meas <= w_h_meas_new;
      end else if (r_hcnt != H_MAX) begin
        r_hcnt <= r_hcnt + 12'd1;
      end

      if (w_vs_rise) begin
        r_v_meas <= w_vcnt_new;
        r_vcnt   <= '0;
      end else begin
        r_vcnt   <= w_vcnt_new;
      end

      if (w_vs_rise)                     r_frame_bad <= 1'b0;
      else if (w_line_bad && w_checking) r_frame_bad <= 1'b1;

      if (w_vs_rise)      r_row <= '0;
      else if (w_de_fall) r_row <= r_row + 10'd1;

      if (video_on) begin
        r_rx_x <= w_de_rise ? '0 : r_rx_x + 11'd1;
        r_rx_y <= w_row_cur;
      end
      r_rx_de <= video_on;
      r_fs    <= w_vs_rise;
    end
  end

  // Lock FSM: state and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_good   <= '0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_good   <= w_good_nxt;
      r_err    <= w_err_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vs_rise) begin
          w_state_nxt = ST_CHECK;
          w_good_nxt  = '0;
        end
      end
      ST_CHECK: begin
        if (w_los) begin
          w_state_nxt = ST_IDLE;
          w_good_nxt  = '0;
          w_err_nxt   = 1'b1;
        end else if (w_vs_rise) begin
          if (w_frame_bad) begin
            w_good_nxt = '0;
            w_err_nxt  = 1'b1;
          end else begin
            w_good_nxt = r_good + 4'd1;
            if ((r_good + 4'd1) == LOCK_W) w_state_nxt = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (w_los) begin
          w_state_nxt = ST_IDLE;
          w_good_nxt  = '0;
          w_err_nxt   = 1'b1;
        end else if (w_line_bad || (w_vs_rise && w_frame_bad)) begin
          w_state_nxt = ST_CHECK;
          w_good_nxt  = '0;
          w_err_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_good_nxt  = '0;
      end
    endcase
  end

  assign rx_x        = r_rx_x;
  assign rx_y        = r_rx_y;
  assign rx_de       = r_rx_de;
  assign h_meas      = r_h_meas;
  assign v_meas      = r_v_meas;
  assign frame_start = r_fs;
  assign locked      = r_locked;
  assign timing_err  = r_err;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a shrunken 24x8 raster (16x5 active) to keep runs short.
module tb_vga_sync_receiver;

  localparam int HT = 24;
  localparam int VT = 8;
  localparam int HV = 16;
  localparam int VV = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic        video_on = 1'b0;
  logic [10:0] rx_x;
  logic [9:0]  rx_y;
  logic        rx_de;
  logic [11:0] h_meas;
  logic [10:0] v_meas;
  logic        frame_start;
  logic        locked;
  logic        timing_err;

  vga_sync_receiver #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_VISIBLE(HV), .V_VISIBLE(VV), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .rx_x(rx_x), .rx_y(rx_y), .rx_de(rx_de), .h_meas(h_meas), .v_meas(v_meas),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder sampled on the falling edge.
  int          err_cnt = 0, err_cyc = 0, fs_cnt = 0, fs_cyc = 0, lock_cyc = 0;
  int          vid_rise_cyc = 0, rise_cyc = 0;
  logic [10:0] rise_x = '0, last_x = '0;
  logic [9:0]  rise_y = '0, last_y = '0;
  logic        prev_locked = 1'b0, prev_de = 1'b0, prev_vid = 1'b0;

  always @(negedge clk) begin
    prev_locked <= locked;
    prev_de     <= rx_de;
    prev_vid    <= video_on;
    if (timing_err)             begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
    if (frame_start)            begin fs_cnt <= fs_cnt + 1;   fs_cyc <= cyc;  end
    if (locked && !prev_locked) lock_cyc <= cyc;
    if (video_on && !prev_vid)  vid_rise_cyc <= cyc;
    if (rx_de && !prev_de)      begin rise_cyc <= cyc; rise_x <= rx_x; rise_y <= rx_y; end
    if (rx_de)                  begin last_x <= rx_x; last_y <= rx_y; end
  end

  int checks = 0;
  int errors = 0;
  int t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_line(input int len, input bit vs, input bit de);
    for (int c = 0; c < len; c++) begin
      hsync    = (c < 2);
      vsync    = vs;
      video_on = de && (c >= 4) && (c < 4 + HV);
      @(posedge clk); #1;
    end
  endtask

  // Lines first..nlines-1 of a frame; line 'stretch' gets one extra clock.
  task automatic drive_frame(input int nlines, input int stretch, input int first);
    for (int l = first; l < nlines; l++)
      drive_line((l == stretch) ? HT + 1 : HT, l < 2, (l >= 1) && (l <= VV));
  endtask

  task automatic quiet(input int n);
    hsync = 1'b0; vsync = 1'b0; video_on = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_x", 32'(rx_x), 0);
    chk("rst_rx_y", 32'(rx_y), 0);
    chk("rst_rx_de", 32'(rx_de), 0);
    chk("rst_h_meas", 32'(h_meas), 0);
    chk("rst_v_meas", 32'(v_meas), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_timing_err", 32'(timing_err), 0);
    reset_n = 1'b1;
    quiet(1);

    // Nominal source from reset; coordinates checked on the locking frame.
    t = cyc; drive_frame(VT, -1, 0);
    chk("t1_fs_cnt", 32'(fs_cnt), 1);
    chk("t1_fs_cyc", 32'(fs_cyc), 32'(t + 1));
    chk("t1_locked_f1", 32'(locked), 0);
    chk("t1_h_meas_f1", 32'(h_meas), 24);
    drive_frame(VT, -1, 0);
    chk("t1_locked_f2", 32'(locked), 0);
    chk("t1_v_meas_f2", 32'(v_meas), 8);
    t = cyc; drive_frame(2, -1, 0);
    chk("t1_lock_cyc", 32'(lock_cyc), 32'(t + 1));
    chk("t1_locked", 32'(locked), 1);
    chk("t4_first_x", 32'(rise_x), 0);
    chk("t4_first_y", 32'(rise_y), 0);
    chk("t4_latency", 32'(rise_cyc), 32'(vid_rise_cyc + 1));
    drive_frame(VT, -1, 2);
    chk("t4_last_x", 32'(last_x), 15);
    chk("t4_last_y", 32'(last_y), 4);
    chk("t1_h_meas", 32'(h_meas), 24);
    chk("t1_v_meas", 32'(v_meas), 8);
    chk("t1_no_err", 32'(err_cnt), 0);
    chk("t1_fs_total", 32'(fs_cnt), 3);

    // One 25-clock line while locked; sticky bad line also fails the partial frame.
    t = cyc; drive_frame(VT, 3, 0);
    chk("t2_err_cnt", 32'(err_cnt), 1);
    chk("t2_err_cyc", 32'(err_cyc), 32'(t + 98));
    chk("t2_unlocked", 32'(locked), 0);
    chk("t2_h_meas", 32'(h_meas), 24);
    drive_frame(VT, -1, 0);
    drive_frame(VT, -1, 0);
    chk("t2_err_cnt2", 32'(err_cnt), 2);
    chk("t2_still_unl", 32'(locked), 0);
    t = cyc; drive_frame(VT, -1, 0);
    chk("t2_relock_cyc", 32'(lock_cyc), 32'(t + 1));
    chk("t2_relocked", 32'(locked), 1);

    // Loss of hsync while locked, then recovery.
    quiet(5000);
    chk("t5_err_cnt", 32'(err_cnt), 3);
    chk("t5_unlocked", 32'(locked), 0);
    drive_frame(1, -1, 0);
    chk("t5_h_meas_sat", 32'(h_meas), 4095);
    drive_frame(VT, -1, 1);
    drive_frame(VT, -1, 0);
    chk("t5_not_yet", 32'(locked), 0);
    chk("t5_err_once", 32'(err_cnt), 3);
    t = cyc; drive_frame(VT, -1, 0);
    chk("t5_relock_cyc", 32'(lock_cyc), 32'(t + 1));

    // Asynchronous reset mid-frame, then a repeat of the nominal sequence.
    drive_frame(3, -1, 0);
    chk("t6_pre_locked", 32'(locked), 1);
    chk("t6_pre_rx_x", 32'(rx_x), 15);
    reset_n = 1'b0;
    #1;
    chk("t6_async_locked", 32'(locked), 0);
    chk("t6_async_h_meas", 32'(h_meas), 0);
    chk("t6_async_v_meas", 32'(v_meas), 0);
    chk("t6_async_rx_x", 32'(rx_x), 0);
    chk("t6_async_rx_y", 32'(rx_y), 0);
    quiet(3);
    reset_n = 1'b1;
    quiet(1);
    t = cyc; drive_frame(VT, -1, 0);
    chk("t6_fs_cyc", 32'(fs_cyc), 32'(t + 1));
    chk("t6_locked_f1", 32'(locked), 0);
    drive_frame(VT, -1, 0);
    chk("t6_locked_f2", 32'(locked), 0);
    chk("t6_v_meas", 32'(v_meas), 8);
    t = cyc; drive_frame(VT, -1, 0);
    chk("t6_lock_cyc", 32'(lock_cyc), 32'(t + 1));
    chk("t6_h_meas", 32'(h_meas), 24);

    // Short frame while in CHECK with one good frame already banked.
    reset_n = 1'b0;
    quiet(3);
    reset_n = 1'b1;
    quiet(1);
    drive_frame(VT, -1, 0);
    drive_frame(VT - 1, -1, 0);
    t = cyc; drive_frame(1, -1, 0);
    chk("t3_err_cnt", 32'(err_cnt), 4);
    chk("t3_err_cyc", 32'(err_cyc), 32'(t + 1));
    chk("t3_v_meas", 32'(v_meas), 7);
    chk("t3_locked", 32'(locked), 0);
    drive_frame(VT, -1, 1);
    drive_frame(VT, -1, 0);
    chk("t3_good_cleared", 32'(locked), 0);
    t = cyc; drive_frame(1, -1, 0);
    chk("t3_lock_cyc", 32'(lock_cyc), 32'(t + 1));
    chk("t3_err_final", 32'(err_cnt), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
